// File: rtl/rv32i_types_pkg.sv
// rv32i_types_pkg
//   Basic RV32I types shared by the pipeline stages.
//   word_t    : one 32-bit architectural word (instruction, address or data).
//   RV32I_NOP : canonical NOP encoding (addi x0, x0, 0). It fills an empty
//               pipeline slot.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RV32I_NOP = 32'h0000_0013;

endpackage : rv32i_types_pkg

// File: rtl/tspp_fetch_stage_pkg.sv
// tspp_fetch_stage_pkg
//   Pipeline-level definitions shared by the two-stage pipeline.
//   fetch_state_t : instruction-memory request FSM states.
//                   IDLE  - no access outstanding.
//                   WAIT  - access outstanding, and its result is wanted.
//                   DRAIN - access outstanding, and its result will be dropped.
//   pc_misaligned : true when a PC is not 4-byte aligned.
package tspp_fetch_stage_pkg;

  import rv32i_types_pkg::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic pc_misaligned(input word_t pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage : tspp_fetch_stage_pkg

// File: rtl/tspp_fetch_stage.sv
// tspp_fetch_stage
//   Instruction-fetch stage of the two-stage pipeline. It owns the PC, selects
//   the next PC, sequences instruction-memory reads and drives the IF/EX
//   register that execute consumes. An access that has been issued always
//   runs to completion. A redirect that occurs while an access is outstanding
//   turns that access into a drain, and its returned word is discarded.
//
// Ports
//   CLK, RST                  clock; synchronous active-high reset
//   pc_en, npc_sel            hazard unit: advance PC / take brj_addr
//   if_ex_stall, if_ex_flush  hazard unit: hold / invalidate IF/EX
//   insert_priv_pc, priv_pc   hazard unit: load trap/return vector
//   iren                      hazard unit: fetch enable
//   brj_addr                  execute: resolved branch/jump target
//   imem_ren, imem_addr       memory request
//   imem_busy                 memory: not done this cycle
//   imem_rdata, imem_error    memory response (valid when ren && !busy)
//   i_mem_busy                to hazard unit: memory side occupied
//   fault_insn, mal_insn      access fault / misaligned PC
//   epc_f, badaddr_f          exception PC / faulting address
//   rv32c_ready               always 1 (no compressed instructions)
//   instr_o, pc_o, valid_o    IF/EX register
module tspp_fetch_stage
  import rv32i_types_pkg::*;
  import tspp_fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pc_en,
  input  logic        npc_sel,
  input  logic        if_ex_stall,
  input  logic        if_ex_flush,
  input  logic        insert_priv_pc,
  input  logic [31:0] priv_pc,
  input  logic        iren,
  input  logic [31:0] brj_addr,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic        imem_busy,
  input  logic [31:0] imem_rdata,
  input  logic        imem_error,
  output logic        i_mem_busy,
  output logic        fault_insn,
  output logic        mal_insn,
  output logic [31:0] epc_f,
  output logic [31:0] badaddr_f,
  output logic        rv32c_ready,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  fetch_state_t state_q, state_d;

  logic [31:0] pc_p0;
  logic [31:0] pc_d;
  logic [31:0] addr_p0;
  logic [31:0] req_addr;
  logic        mal;
  logic        kill;
  logic        ren;
  logic        completion;
  logic        issue_busy;

  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic        vld_p1;

  assign mal  = pc_misaligned(pc_p0);
  assign kill = if_ex_flush || insert_priv_pc || (pc_en && npc_sel);

  always_comb begin
    pc_d = pc_p0;
    if (insert_priv_pc) begin
      pc_d = priv_pc;
    end else if (pc_en && npc_sel) begin
      pc_d = brj_addr;
    end else if (pc_en) begin
      pc_d = pc_p0 + 32'd4;
    end
  end

  // Request side: IDLE issues from the live PC. WAIT/DRAIN replay the
  // captured address until the memory finishes.
  always_comb begin
    ren      = 1'b0;
    req_addr = pc_p0;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        ren      = iren && !mal;
        req_addr = pc_p0;
        if (ren && imem_busy) begin
          state_d = kill ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        ren      = 1'b1;
        req_addr = addr_p0;
        if (!imem_busy) begin
          state_d = IDLE;
        end else if (kill) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        ren      = 1'b1;
        req_addr = addr_p0;
        if (!imem_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Reset overrides the request. The next state is irrelevant here
    // because the register block forces IDLE.
    if (RST) begin
      ren = 1'b0;
    end
  end

  assign completion = ren && !imem_busy && (state_q != DRAIN);
  assign issue_busy = (state_q == IDLE) && ren && imem_busy;

  // ---- stage boundary: PC / request state -> IF/EX register ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      pc_p0    <= RESET_PC;
      addr_p0  <= RESET_PC;
      vld_p1   <= 1'b0;
      instr_p1 <= RV32I_NOP;
      pc_p1    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_p0   <= pc_d;
      if (issue_busy) begin
        addr_p0 <= pc_p0;
      end
      if (if_ex_flush) begin
        vld_p1   <= 1'b0;
        instr_p1 <= RV32I_NOP;
      end else if (if_ex_stall) begin
        vld_p1   <= vld_p1;
      end else if (completion && !kill) begin
        vld_p1   <= 1'b1;
        instr_p1 <= imem_rdata;
        pc_p1    <= req_addr;
      end else begin
        vld_p1   <= 1'b0;
        instr_p1 <= RV32I_NOP;
      end
    end
  end

  assign imem_ren    = ren;
  assign imem_addr   = req_addr;
  assign i_mem_busy  = (ren && imem_busy) || (state_q == DRAIN);
  assign fault_insn  = completion && imem_error;
  assign mal_insn    = mal && iren;
  assign epc_f       = pc_p0;
  assign badaddr_f   = pc_p0;
  assign rv32c_ready = 1'b1;
  assign instr_o     = instr_p1;
  assign pc_o        = pc_p1;
  assign valid_o     = vld_p1;

endmodule : tspp_fetch_stage

// File: tb/tb_tspp_fetch_stage.sv
module tb_tspp_fetch_stage;
  import rv32i_types_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0200;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        pc_en = 1'b0, npc_sel = 1'b0, if_ex_stall = 1'b0, if_ex_flush = 1'b0;
  logic        insert_priv_pc = 1'b0, iren = 1'b0;
  logic [31:0] priv_pc = '0, brj_addr = '0;
  logic        imem_busy = 1'b0, imem_error = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_ren, i_mem_busy, fault_insn, mal_insn, rv32c_ready, valid_o;
  logic [31:0] imem_addr, epc_f, badaddr_f, instr_o, pc_o;

  always #5 CLK = ~CLK;

  tspp_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RST(RST), .pc_en(pc_en), .npc_sel(npc_sel),
    .if_ex_stall(if_ex_stall), .if_ex_flush(if_ex_flush),
    .insert_priv_pc(insert_priv_pc), .priv_pc(priv_pc), .iren(iren),
    .brj_addr(brj_addr), .imem_ren(imem_ren), .imem_addr(imem_addr),
    .imem_busy(imem_busy), .imem_rdata(imem_rdata), .imem_error(imem_error),
    .i_mem_busy(i_mem_busy), .fault_insn(fault_insn), .mal_insn(mal_insn),
    .epc_f(epc_f), .badaddr_f(badaddr_f), .rv32c_ready(rv32c_ready),
    .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o)
  );

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        ibusy;
    logic        mal;
    logic [31:0] epc;
    logic        fault;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } txn_t;

  exp_t comb_q[$];
  txn_t txn_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: architectural PC, at most one outstanding access
  // (with a flag saying whether its result is still wanted), and the
  // IF/EX register contents.
  logic [31:0] m_pc = RST_PC;
  bit          m_out = 1'b0;
  bit          m_doomed = 1'b0;
  logic [31:0] m_oaddr = RST_PC;
  bit          m_vld = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pc_o = RST_PC;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the current inputs for one cycle: predict the outputs, advance the model, and clock.
  task automatic step();
    bit          ren, kill, comp;
    logic [31:0] addr;
    exp_t        e;
    addr = m_out ? m_oaddr : m_pc;
    if (RST)        ren = 1'b0;
    else if (m_out) ren = 1'b1;
    else            ren = iren && (m_pc[1:0] == 2'b00);
    kill = if_ex_flush || insert_priv_pc || (pc_en && npc_sel);
    comp = ren && !imem_busy && !(m_out && m_doomed);
    e.ren   = ren;
    e.addr  = addr;
    e.ibusy = (ren && imem_busy) || (m_out && m_doomed);
    e.mal   = iren && (m_pc[1:0] != 2'b00);
    e.epc   = m_pc;
    e.fault = comp && imem_error;
    e.vld   = m_vld;
    e.instr = m_instr;
    e.pc    = m_pc_o;
    comb_q.push_back(e);
    if (RST) begin
      m_pc = RST_PC; m_out = 1'b0; m_doomed = 1'b0;
      m_vld = 1'b0; m_instr = NOP; m_pc_o = RST_PC;
    end else begin
      if (if_ex_flush) begin
        m_vld = 1'b0; m_instr = NOP;
      end else if (!if_ex_stall) begin
        if (comp && !kill) begin
          m_vld = 1'b1; m_instr = imem_rdata; m_pc_o = addr;
          txn_q.push_back('{pc: addr, instr: imem_rdata});
        end else begin
          m_vld = 1'b0; m_instr = NOP;
        end
      end
      if (m_out) begin
        if (!imem_busy) m_out = 1'b0;
        else if (kill)  m_doomed = 1'b1;
      end else if (ren && imem_busy) begin
        m_out = 1'b1; m_oaddr = m_pc; m_doomed = kill;
      end
      if (insert_priv_pc)         m_pc = priv_pc;
      else if (pc_en && npc_sel)  m_pc = brj_addr;
      else if (pc_en)             m_pc = m_pc + 32'd4;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc(input bit rst, input bit ir, input bit pe, input bit ns,
                     input bit st, input bit fl, input bit ip,
                     input logic [31:0] pp, input logic [31:0] ba,
                     input bit bz, input logic [31:0] rd, input bit er);
    RST = rst; iren = ir; pc_en = pe; npc_sel = ns; if_ex_stall = st;
    if_ex_flush = fl; insert_priv_pc = ip; priv_pc = pp; brj_addr = ba;
    imem_busy = bz; imem_rdata = rd; imem_error = er;
    step();
  endtask

  // Monitor: per-cycle output check plus an in-order scoreboard of latched instructions.
  bit   edge_stall = 1'b0;
  bit   edge_rst = 1'b1;
  exp_t mon_e;
  txn_t mon_t;

  always @(posedge CLK) begin
    edge_stall = if_ex_stall;
    edge_rst   = RST;
  end

  always @(negedge CLK) begin
    if (comb_q.size() > 0) begin
      mon_e = comb_q.pop_front();
      check("imem_ren",    {31'd0, imem_ren},    {31'd0, mon_e.ren});
      check("imem_addr",   imem_addr,            mon_e.addr);
      check("i_mem_busy",  {31'd0, i_mem_busy},  {31'd0, mon_e.ibusy});
      check("mal_insn",    {31'd0, mal_insn},    {31'd0, mon_e.mal});
      check("epc_f",       epc_f,                mon_e.epc);
      check("badaddr_f",   badaddr_f,            mon_e.epc);
      check("fault_insn",  {31'd0, fault_insn},  {31'd0, mon_e.fault});
      check("rv32c_ready", {31'd0, rv32c_ready}, 32'd1);
      check("valid_o",     {31'd0, valid_o},     {31'd0, mon_e.vld});
      check("instr_o",     instr_o,              mon_e.instr);
      check("pc_o",        pc_o,                 mon_e.pc);
    end
    if (valid_o && !edge_stall && !edge_rst) begin
      if (txn_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL txn_unexpected: got pc %h instr %h, expected no new instruction", pc_o, instr_o);
      end else begin
        mon_t = txn_q.pop_front();
        check("txn_pc",    pc_o,    mon_t.pc);
        check("txn_instr", instr_o, mon_t.instr);
      end
    end
  end

  initial begin
    logic [31:0] r;
    @(posedge CLK);
    #1;
    // reset held, then stream from RESET_PC
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'hA, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'hB, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'hC, 0);
    // three wait cycles, then completion
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'hD, 0);
    // flush with redirect mid-access, drain, then fetch at 0x400
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
    cyc(0, 1, 1, 1, 0, 1, 0, 0, 32'h400, 1, 32'h0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBAD, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'hE, 0);
    // misaligned target, then trap vector
    cyc(0, 1, 1, 1, 0, 0, 0, 0, 32'h402, 0, 32'hF, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1, 32'h100, 0, 0, 32'h0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h11, 0);
    // stall over a completion, then refetch of the same PC
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h22, 0);
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h23, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h33, 0);
    // bus error on a completion; flush coinciding with completion
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h44, 1);
    cyc(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 32'h55, 0);
    // reset in the middle of an outstanding access
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h66, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RST            = ($urandom_range(0, 199) == 0);
      iren           = ($urandom_range(0, 7) != 0);
      pc_en          = $urandom_range(0, 1);
      npc_sel        = ($urandom_range(0, 3) == 0);
      if_ex_stall    = ($urandom_range(0, 5) == 0);
      if_ex_flush    = ($urandom_range(0, 9) == 0);
      insert_priv_pc = ($urandom_range(0, 19) == 0);
      r              = $urandom;
      priv_pc        = {r[31:2], 2'b00};
      r              = $urandom;
      brj_addr       = ($urandom_range(0, 7) == 0) ? r : {r[31:2], 2'b00};
      imem_busy      = ($urandom_range(0, 4) < 2);
      imem_rdata     = $urandom;
      imem_error     = ($urandom_range(0, 15) == 0);
      step();
    end
    RST = 1'b0; iren = 1'b0; pc_en = 1'b0; npc_sel = 1'b0; if_ex_stall = 1'b0;
    if_ex_flush = 1'b0; insert_priv_pc = 1'b0; imem_busy = 1'b0;
    @(negedge CLK);
    #1;
    check("txn_q_leftover", txn_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_tspp_fetch_stage
